// File: rtl/pwm_demod.sv
// PWM demodulator: counts synchronised high cycles over each 2^WIDTH-clock frame and
// emits the signed sample that the PWM DAC encoded, optionally aligned to falling edges.
module pwm_demod #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                    clock,
  input  logic                    clock_sreset,
  input  logic                    pwm_in,
  input  logic                    align_en,
  output logic                    data_valid,
  output logic signed [WIDTH-1:0] data,
  output logic                    locked
);

  localparam int CW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_FRAMES);
  localparam logic signed [WIDTH+1:0] MAXV = (WIDTH+2)'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [WIDTH+1:0] MINV = -(WIDTH+2)'(1 <<< (WIDTH - 1));

  typedef enum logic {SEARCH, RUN} state_t;

  state_t                   state_reg, state_next;
  logic [SYNC_STAGES-1:0]   sync_reg;
  logic                     prev_reg;
  logic                     align_reg;
  logic [WIDTH-1:0]         cnt_reg, cnt_next;
  logic [WIDTH:0]           h_reg, h_next;
  logic [CW-1:0]            clean_reg, clean_next;
  logic                     valid_next;
  logic signed [WIDTH-1:0]  data_next;
  logic                     locked_next;

  logic                     s;
  logic                     fall;
  logic [WIDTH:0]           hf;
  logic signed [WIDTH+1:0]  diff;
  logic signed [WIDTH-1:0]  sample;

  assign s    = sync_reg[SYNC_STAGES-1];
  assign fall = prev_reg & ~s;
  assign hf   = h_reg + {{WIDTH{1'b0}}, s};
  assign diff = MAXV - $signed({1'b0, hf});

  // Only a fully-high frame (hf = 2^WIDTH) falls below the negative limit.
  always_comb begin
    sample = diff[WIDTH-1:0];
    if (diff < MINV)
      sample = MINV[WIDTH-1:0];
    else if (diff > MAXV)
      sample = MAXV[WIDTH-1:0];
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    h_next      = h_reg;
    clean_next  = clean_reg;
    valid_next  = 1'b0;
    data_next   = data;
    locked_next = locked;
    case (state_reg)
      SEARCH: begin
        cnt_next    = '0;
        h_next      = '0;
        locked_next = 1'b0;
        // The edge cycle itself is frame position 0.
        if (fall) begin
          state_next = RUN;
          cnt_next   = WIDTH'(1);
          h_next     = (WIDTH+1)'(s);
        end
      end
      RUN: begin
        if (!align_reg)
          locked_next = 1'b1;
        if (align_reg && fall && (cnt_reg != '0)) begin
          cnt_next    = WIDTH'(1);
          h_next      = (WIDTH+1)'(s);
          locked_next = 1'b0;
          clean_next  = '0;
        end else if (&cnt_reg) begin
          cnt_next   = '0;
          h_next     = '0;
          valid_next = 1'b1;
          data_next  = sample;
          if (align_reg) begin
            if (clean_reg < LOCK_MAX)
              clean_next = clean_reg + 1'b1;
            if (clean_next == LOCK_MAX)
              locked_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
          h_next   = hf;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      sync_reg   <= '0;
      prev_reg   <= 1'b0;
      align_reg  <= align_en;
      state_reg  <= align_en ? SEARCH : RUN;
      cnt_reg    <= '0;
      h_reg      <= '0;
      clean_reg  <= '0;
      data_valid <= 1'b0;
      data       <= '0;
      locked     <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
      prev_reg   <= s;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      h_reg      <= h_next;
      clean_reg  <= clean_next;
      data_valid <= valid_next;
      data       <= data_next;
      locked     <= locked_next;
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod: stimulus pushes expected strobes (sample, lock, cycle)
// into a queue; a negedge monitor pops and compares on every data_valid.
`timescale 1ns/1ps
module tb_pwm_demod;
  localparam int W     = 12;
  localparam int FRAME = 4096;

  logic                clock = 1'b0;
  logic                clock_sreset = 1'b1;
  logic                pwm_in = 1'b0;
  logic                align_en = 1'b0;
  logic                data_valid;
  logic signed [W-1:0] data;
  logic                locked;

  pwm_demod #(.WIDTH(W), .SYNC_STAGES(2), .LOCK_FRAMES(4)) dut (
    .clock       (clock),
    .clock_sreset(clock_sreset),
    .pwm_in      (pwm_in),
    .align_en    (align_en),
    .data_valid  (data_valid),
    .data        (data),
    .locked      (locked)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int d;
    int lk;
    int at;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int d, input int lk, input int at);
    exp_t e;
    e.d = d;
    e.lk = lk;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset(input logic al, input logic p, output int r);
    clock_sreset = 1'b1;
    align_en = al;
    pwm_in = p;
    repeat (3) step();
    check("reset data_valid", int'(data_valid), 0);
    check("reset data", int'(data), 0);
    check("reset locked", int'(locked), 0);
    clock_sreset = 1'b0;
    r = cyc;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({name, " pending strobes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!clock_sreset && data_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected strobe: cycle %0d data %0d, required no strobe", cyc, data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("strobe cycle %0d data %0d locked %0d (expect %0d/%0d @%0d)",
                 cyc, data, locked, mon_e.d, mon_e.lk, mon_e.at);
        check("strobe data", int'(data), mon_e.d);
        check("strobe locked", int'(locked), mon_e.lk);
        check("strobe cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, p, q, f0, n;
    int dl[5] = '{0, 2047, -2048, 1000, -1};

    // Free-running, input low: max positive sample, locked immediately.
    do_reset(1'b0, 1'b0, r);
    step();
    check("free-run locked", int'(locked), 1);
    push(2047, 1, r + FRAME);
    drain("t1", FRAME + 100);

    // Free-running, input high: first frame sees two reset-zeroed sync samples.
    do_reset(1'b0, 1'b1, r);
    push(-2047, 1, r + FRAME);
    push(-2048, 1, r + 2 * FRAME);
    drain("t2", 2 * FRAME + 100);

    // Reset at cnt=2000 of the third frame; partial high count must be discarded.
    wait_to(r + 2 * FRAME + 2000);
    clock_sreset = 1'b1;
    pwm_in = 1'b0;
    step();
    check("mid-reset data_valid", int'(data_valid), 0);
    check("mid-reset data", int'(data), 0);
    check("mid-reset locked", int'(locked), 0);
    clock_sreset = 1'b0;
    r = cyc;
    push(2047, 1, r + FRAME);
    drain("t6", FRAME + 100);

    // DAC loopback with alignment; lead frame supplies the first falling edge.
    do_reset(1'b1, 1'b0, r);
    step();
    check("search locked", int'(locked), 0);
    f0 = cyc;
    p = f0 + FRAME;
    for (int j = 1; j <= 5; j++)
      push(dl[j-1], (j >= 4) ? 1 : 0, p + FRAME + 2 + FRAME * (j - 1));
    for (int k = 0; k < 6; k++) begin
      n = (k == 0) ? 2047 : 2047 - dl[k-1];
      for (int i = 0; i < FRAME; i++) begin
        pwm_in = (i >= FRAME - n);
        step();
      end
    end
    pwm_in = 1'b0;
    drain("t3", FRAME + 100);

    // Start mid-pulse: nothing until the first falling edge.
    do_reset(1'b1, 1'b1, r);
    repeat (300) step();
    check("mid-pulse locked", int'(locked), 0);
    check("mid-pulse no strobe pending", exp_q.size(), 0);
    p = cyc;
    pwm_in = 1'b0;
    for (int j = 1; j <= 4; j++)
      push(2047, (j >= 4) ? 1 : 0, p + FRAME + 2 + FRAME * (j - 1));
    wait_to(p + 4 * FRAME + 4);
    check("t4 strobes seen", exp_q.size(), 0);
    check("locked after 4 frames", int'(locked), 1);

    // Misaligned falling edge lands at cnt=1234 of the fifth frame.
    q = p + 4 * FRAME + 1234;
    wait_to(q - 10);
    pwm_in = 1'b1;
    wait_to(q);
    pwm_in = 1'b0;
    wait_to(q + 2);
    check("locked before misalign", int'(locked), 1);
    step();
    check("locked after misalign", int'(locked), 0);
    for (int j = 1; j <= 4; j++)
      push(2047, (j >= 4) ? 1 : 0, q + FRAME + 2 + FRAME * (j - 1));
    drain("t5", 4 * FRAME + 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pwm_demod.md
Name: pwm_demod

Overview:
- Receive-side counterpart of the team's PWM DAC. Recovers a signed WIDTH-bit sample stream from a 1-bit PWM input by counting high cycles over each 2^WIDTH-cycle frame.
- Used for loopback/self-test of the PWM output path.
- Also used to digitise an external PWM or comparator stream in the SDR datapath.
- The frame is free-running, or aligned to the input's falling edge when `align_en` is set.

Parameters:
- WIDTH, 12: sample width; frame length is 2^WIDTH clocks.
- SYNC_STAGES, 2: synchroniser flops on `pwm_in`; minimum 2.
- LOCK_FRAMES, 4: consecutive clean frames required before `locked` asserts; minimum 1.

Ports:
- clock, input, 1: system clock.
- clock_sreset, input, 1: synchronous active-high reset.
- pwm_in, input, 1: asynchronous PWM stream.
- align_en, input, 1: 1 = align frames to falling edges of `pwm_in`; 0 = free-running frames.
- data_valid, output, 1: one-cycle strobe, one per completed frame.
- data, output, WIDTH signed: recovered sample; held between strobes.
- locked, output, 1: frame alignment confirmed.

Behaviour:
- One clock; reset is synchronous and active-high (`clock`, `clock_sreset`).
- Reset values:
  - synchroniser flops, edge-history flop, frame counter, high-count accumulator: 0.
  - `data_valid`: 0. `data`: 0. `locked`: 0.
  - state: SEARCH if `align_en`=1 at reset, else RUN.
- Reset mid-frame discards the partial accumulation; no `data_valid` is produced for that frame.
- Synchronisation:
  - `s` = `pwm_in` after SYNC_STAGES flops.
  - Falling edge = `s`=0 while the previous `s`=1.
  - All counting uses `s` only.
- Counter and accumulator:
  - Frame counter `cnt` is WIDTH bits; accumulator `H` is WIDTH+1 bits.
  - In RUN, each cycle: `H` += `s`; `cnt` += 1, wrapping to 0.
- Frame end (RUN and `cnt` = all-ones):
  - `Hf` = `H` + `s`, range 0..2^WIDTH.
  - `data` <= 2^(WIDTH-1) - 1 - `Hf`, computed WIDTH+2 bits wide, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Only `Hf` = 2^WIDTH saturates, giving -2^(WIDTH-1).
  - `data_valid` <= 1 for the next cycle only.
  - `H` <= 0, `cnt` <= 0.
  - This is the exact inverse of the PWM DAC encoding, where high count = 2^(WIDTH-1) - 1 - d.
- Latency: `data_valid` asserts 1 clock after the last sampled cycle of the frame, plus SYNC_STAGES clocks from the pin.
- States:
  - SEARCH (align_en=1 only):
    - `cnt` and `H` held at 0; `locked`=0; no strobes.
    - On a falling edge, go to RUN; that edge cycle is counted as `cnt`=0, with its `s` (0) included.
  - RUN with align_en=1, falling edge:
    - At `cnt`=0: consistent; no action.
    - At `cnt`≠0: misalignment. Discard the frame (no strobe), `locked` <= 0, clear the clean-frame count, restart the frame at `cnt`=0 with this cycle counted.
  - RUN with align_en=1, clean frame end: clean-frame count += 1, saturating at LOCK_FRAMES. `locked` <= 1 when it reaches LOCK_FRAMES.
  - Frames with no edges (0% or 100% duty) count as clean.
  - RUN with align_en=0: edges are ignored; `locked` held at 1 from the first cycle after reset.
- `align_en` changes are sampled only at reset; behaviour on a mid-operation change is undefined.
- Frame end coinciding with a misalignment edge: the misalignment wins (no strobe).

Test Plan:
- align_en=0, `pwm_in`=0 constant → `data_valid` every 4096 clocks, `data`=2047; `locked`=1 from the first cycle after reset.
- align_en=0, `pwm_in`=1 constant → `data`=-2048 (saturated, `Hf`=4096), every 4096 clocks.
- Loopback from the PWM DAC (WIDTH=12), align_en=1, DAC input d ∈ {0, 2047, -2048, 1000, -1} → recovered `data` equals d, one frame (plus pipeline delay) later; `locked` asserts after 4 frames.
- align_en=1, start mid-pulse → no strobe until the first falling edge; first strobe 4096 clocks after that edge.
- In RUN/locked, inject a falling edge at `cnt`=1234 → no strobe for that frame, `locked`=0 next cycle, new frame starts at the edge, `locked` returns after LOCK_FRAMES clean frames.
- Assert `clock_sreset` at `cnt`=2000 → all outputs 0 next cycle; next strobe reflects only post-reset samples.
